// File: rtl/sa_x_skew_feeder_if.sv
// Vector handshake between the activation buffer and the x-skew feeder.
// The buffer drives whole S-lane row-vectors; the feeder answers with ready once per tick.
interface sa_x_skew_feeder_if #(
   parameter int S  = 64,
   parameter int DW = 16
);
   logic            I_VEC_VLD;
   logic [S*DW-1:0] I_VEC;
   logic            O_VEC_RDY;

   modport master (
      output I_VEC_VLD,
      output I_VEC,
      input  O_VEC_RDY
   );

   modport slave (
      input  I_VEC_VLD,
      input  I_VEC,
      output O_VEC_RDY
   );
endinterface

// File: rtl/sa_x_skew_feeder.sv
// Feeds X row-vectors into the systolic array with a per-lane tick skew,
// generating start/end flags on the PE update cadence and flushing with zeros.
module sa_x_skew_feeder #(
   parameter int S      = 64,
   parameter int DW     = 16,
   parameter int PERIOD = 5,
   parameter int FLUSH  = 64
) (
   input  logic              I_CLK,
   input  logic              I_RST,
   input  logic              I_START,
   input  logic [15:0]       I_LEN,
   sa_x_skew_feeder_if.slave vec_if,
   output logic [S*DW-1:0]   O_X,
   output logic              O_SA_START,
   output logic              O_SA_END,
   output logic              O_BUSY,
   output logic              O_DONE,
   output logic              O_UNDERRUN
);

   localparam int CW          = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int DCW         = (S + FLUSH > 1) ? $clog2(S + FLUSH) : 1;
   localparam int DRAIN_TICKS = S - 1 + FLUSH;

   localparam logic [CW-1:0]  CNT_LAST   = CW'(PERIOD - 1);
   localparam logic [DCW-1:0] DRAIN_INIT = DCW'(DRAIN_TICKS);
   localparam logic [DCW-1:0] DRAIN_ONE  = DCW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           state_reg;
   logic [CW-1:0]    cnt_reg;
   logic [15:0]      rem_reg;
   logic [DCW-1:0]   drain_reg;
   logic             sa_start_reg;
   logic             sa_end_reg;
   logic             busy_reg;
   logic             done_reg;
   logic             underrun_reg;

   logic             tick;
   logic             vec_rdy;
   logic             accept;
   logic             last_tick;
   logic [S*DW-1:0]  inj_vec;

   // Ticks only exist while a job is active, so cnt held at 0 in IDLE never fires one.
   always_comb begin
      tick      = (state_reg != IDLE) && (cnt_reg == CNT_LAST);
      vec_rdy   = (state_reg == FEED) && tick && (rem_reg != 16'd0);
      accept    = vec_rdy && vec_if.I_VEC_VLD;
      last_tick = tick &&
                  (((state_reg == DRAIN) && (drain_reg == DRAIN_ONE)) ||
                   ((DRAIN_TICKS == 0) && accept && (rem_reg == 16'd1)));
      inj_vec   = accept ? vec_if.I_VEC : '0;
   end

   assign vec_if.O_VEC_RDY = vec_rdy;

   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         rem_reg      <= '0;
         drain_reg    <= '0;
         sa_start_reg <= 1'b0;
         sa_end_reg   <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         underrun_reg <= 1'b0;
      end else begin
         sa_start_reg <= 1'b0;
         sa_end_reg   <= 1'b0;
         done_reg     <= 1'b0;

         case (state_reg)
            IDLE: begin
               cnt_reg <= '0;
               if (I_START) begin
                  if (I_LEN != 16'd0) begin
                     state_reg    <= FEED;
                     rem_reg      <= I_LEN;
                     sa_start_reg <= 1'b1;
                     underrun_reg <= 1'b0;
                     busy_reg     <= 1'b1;
                  end else begin
                     done_reg <= 1'b1;
                  end
               end
            end

            FEED: begin
               cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
               if (tick) begin
                  if (accept) begin
                     rem_reg <= rem_reg - 16'd1;
                     if (rem_reg == 16'd1) begin
                        state_reg <= DRAIN;
                        drain_reg <= DRAIN_INIT;
                     end
                  end else begin
                     // Missing vector: a zero slot is injected and the job stretches by one tick.
                     underrun_reg <= 1'b1;
                  end
               end
            end

            DRAIN: begin
               cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
               if (tick) begin
                  drain_reg <= drain_reg - 1'b1;
               end
            end

            default: begin
               state_reg <= IDLE;
               cnt_reg   <= '0;
               busy_reg  <= 1'b0;
            end
         endcase

         if (last_tick) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
            sa_end_reg <= 1'b1;
            done_reg   <= 1'b1;
         end
      end
   end

   // Lane j delays its element by j ticks before the shared output register stage.
   genvar gi;
   generate
      for (gi = 0; gi < S; gi++) begin : g_lane
         logic [DW-1:0] x_reg;

         if (gi == 0) begin : g_direct
            always_ff @(posedge I_CLK or posedge I_RST) begin
               if (I_RST) begin
                  x_reg <= '0;
               end else if (last_tick) begin
                  x_reg <= '0;
               end else if (tick) begin
                  x_reg <= inj_vec[0 +: DW];
               end
            end
         end else begin : g_skew
            logic [DW-1:0] stage_reg [0:gi-1];

            always_ff @(posedge I_CLK or posedge I_RST) begin
               if (I_RST) begin
                  for (int k = 0; k < gi; k++) begin
                     stage_reg[k] <= '0;
                  end
                  x_reg <= '0;
               end else if (last_tick) begin
                  for (int k = 0; k < gi; k++) begin
                     stage_reg[k] <= '0;
                  end
                  x_reg <= '0;
               end else if (tick) begin
                  stage_reg[0] <= inj_vec[gi*DW +: DW];
                  for (int k = 1; k < gi; k++) begin
                     stage_reg[k] <= stage_reg[k-1];
                  end
                  x_reg <= stage_reg[gi-1];
               end
            end
         end

         assign O_X[gi*DW +: DW] = x_reg;
      end
   endgenerate

   assign O_SA_START = sa_start_reg;
   assign O_SA_END   = sa_end_reg;
   assign O_BUSY     = busy_reg;
   assign O_DONE     = done_reg;
   assign O_UNDERRUN = underrun_reg;

endmodule

// File: tb/tb_sa_x_skew_feeder.sv
// Scoreboard bench for sa_x_skew_feeder: jobs are planned tick by tick, the expected
// per-cycle outputs are queued up front and a negedge monitor pops and compares them.
module tb_sa_x_skew_feeder;

   localparam int S           = 4;
   localparam int DW          = 16;
   localparam int PERIOD      = 5;
   localparam int FLUSH       = 4;
   localparam int W           = S * DW;
   localparam int DRAIN_TICKS = S - 1 + FLUSH;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [15:0]   len = '0;
   logic [W-1:0]  o_x;
   logic          o_sa_start, o_sa_end, o_busy, o_done, o_underrun;

   sa_x_skew_feeder_if #(.S(S), .DW(DW)) vif ();

   sa_x_skew_feeder #(.S(S), .DW(DW), .PERIOD(PERIOD), .FLUSH(FLUSH)) dut (
      .I_CLK      (clk),
      .I_RST      (rst),
      .I_START    (start),
      .I_LEN      (len),
      .vec_if     (vif),
      .O_X        (o_x),
      .O_SA_START (o_sa_start),
      .O_SA_END   (o_sa_end),
      .O_BUSY     (o_busy),
      .O_DONE     (o_done),
      .O_UNDERRUN (o_underrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // fl = {sa_start, sa_end, done, busy, underrun, vec_rdy}
   typedef struct {
      int           cyc;
      logic [W-1:0] x;
      logic [5:0]   fl;
   } exp_t;

   exp_t         exp_q[$];
   logic [W-1:0] vec_plan[$];
   bit           drop_plan[$];
   int           drop_pct = 0;
   bit           ur_model = 1'b0;
   bit           mon_on = 1'b0;
   int           n_cmp = 0;
   int           n_bad = 0;

   initial begin
      exp_t       e;
      logic [5:0] got;
      forever begin
         @(negedge clk);
         if (mon_on) begin
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL sched cyc %0d: got no expectation, want one queued", cyc);
            end else begin
               e   = exp_q.pop_front();
               got = {o_sa_start, o_sa_end, o_done, o_busy, o_underrun, vif.O_VEC_RDY};
               n_cmp++;
               if (o_x !== e.x) begin
                  n_bad++;
                  $display("FAIL o_x cyc %0d: got %h want %h", e.cyc, o_x, e.x);
               end
               n_cmp++;
               if (got !== e.fl) begin
                  n_bad++;
                  $display("FAIL flags cyc %0d: got st/en/dn/bz/ur/rdy=%b want %b", e.cyc, got, e.fl);
               end
            end
         end
      end
   end

   function automatic logic [W-1:0] rand_vec();
      logic [W-1:0] v;
      v = '0;
      for (int j = 0; j < S; j++) v[j*DW +: DW] = DW'($urandom);
      return v;
   endfunction

   function automatic logic [W-1:0] mk_vec(input int base);
      logic [W-1:0] v;
      v = '0;
      for (int j = 0; j < S; j++) v[j*DW +: DW] = DW'(base + j + 1);
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_idle();
      exp_t e;
      e.cyc = cyc;
      e.x   = '0;
      e.fl  = {4'b0000, ur_model, 1'b0};
      exp_q.push_back(e);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         push_idle();
         start         = 1'b0;
         len           = 16'($urandom);
         vif.I_VEC_VLD = 1'($urandom);
         vif.I_VEC     = rand_vec();
         step();
      end
   endtask

   task automatic reset_cycles(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.cyc = cyc;
         e.x   = '0;
         e.fl  = '0;
         exp_q.push_back(e);
         step();
      end
   endtask

   // rst_at / spur_at are cycle offsets from the I_START cycle; negative disables.
   task automatic run_job(input int L, input int rst_at, input int spur_at);
      int           s, f_ticks, t_ticks, e_cyc, acc, t, fu, ticks_done, m;
      logic [W-1:0] inj[$];
      bit           vt[$];
      logic [W-1:0] lv;
      exp_t         e;

      s = cyc;
      while (vec_plan.size() < L) vec_plan.push_back(rand_vec());

      acc = 0; t = 0; fu = -1;
      while (acc < L) begin
         bit v;
         if (t < drop_plan.size()) v = drop_plan[t];
         else v = ($urandom_range(0, 99) >= drop_pct);
         vt.push_back(v);
         if (v) begin
            inj.push_back(vec_plan[acc]);
            acc++;
         end else begin
            inj.push_back('0);
            if (fu < 0) fu = t;
         end
         t++;
      end
      f_ticks = inj.size();
      t_ticks = f_ticks + DRAIN_TICKS;
      e_cyc   = (L == 0) ? s + 1 : s + PERIOD * t_ticks + 1;

      for (int c = s; c <= e_cyc; c++) begin
         if (rst_at >= 0 && c >= s + rst_at) break;
         e.cyc = c;
         e.x   = '0;
         e.fl  = '0;
         if (c == s) begin
            e.fl[1] = ur_model;
         end else if (L == 0) begin
            e.fl[3] = 1'b1;
            e.fl[1] = ur_model;
         end else begin
            e.fl[5] = (c == s + 1);
            e.fl[4] = (c == e_cyc);
            e.fl[3] = (c == e_cyc);
            e.fl[2] = (c < e_cyc);
            e.fl[1] = (fu >= 0) && (s + PERIOD * (fu + 1) < c);
            e.fl[0] = ((c - s) % PERIOD == 0) && ((c - s) / PERIOD <= f_ticks);
            if (c < e_cyc) begin
               ticks_done = (c - s - 1) / PERIOD;
               for (int j = 0; j < S; j++) begin
                  m = ticks_done - 1 - j;
                  if (m >= 0 && m < f_ticks) begin
                     lv = inj[m];
                     e.x[j*DW +: DW] = lv[j*DW +: DW];
                  end
               end
            end
         end
         exp_q.push_back(e);
      end
      if (L > 0) ur_model = (fu >= 0);

      start         = 1'b1;
      len           = 16'(L);
      vif.I_VEC_VLD = 1'($urandom);
      vif.I_VEC     = rand_vec();
      step();

      for (int c = s + 1; c <= e_cyc; c++) begin
         if (rst_at >= 0 && c == s + rst_at) begin
            ur_model = 1'b0;
            start    = 1'b0;
            rst      = 1'b1;
            reset_cycles(2);
            rst      = 1'b0;
            return;
         end
         start = (c == s + spur_at);
         len   = 16'($urandom);
         if (((c - s) % PERIOD == 0) && ((c - s) / PERIOD - 1 < f_ticks)) begin
            t = (c - s) / PERIOD - 1;
            vif.I_VEC_VLD = vt[t];
            vif.I_VEC     = vt[t] ? inj[t] : rand_vec();
         end else begin
            vif.I_VEC_VLD = 1'($urandom);
            vif.I_VEC     = rand_vec();
         end
         step();
      end
   endtask

   task automatic load_directed();
      vec_plan.delete();
      drop_plan.delete();
      drop_pct = 0;
      vec_plan.push_back(mk_vec(16'h0000));
      vec_plan.push_back(mk_vec(16'h0010));
      vec_plan.push_back(mk_vec(16'h0020));
   endtask

   initial begin
      vif.I_VEC_VLD = 1'b0;
      vif.I_VEC     = '0;
      step();
      mon_on = 1'b1;
      reset_cycles(2);
      rst = 1'b0;
      idle_cycles(2);

      load_directed();
      run_job(3, -1, -1);
      idle_cycles(3);

      load_directed();
      drop_plan.push_back(1'b1);
      drop_plan.push_back(1'b0);
      run_job(3, -1, -1);
      idle_cycles(3);

      load_directed();
      run_job(0, -1, -1);
      idle_cycles(3);

      load_directed();
      run_job(3, -1, 12);
      idle_cycles(3);

      load_directed();
      run_job(3, 20, -1);
      idle_cycles(8);
      load_directed();
      run_job(3, -1, -1);
      idle_cycles(2);

      for (int k = 0; k < 25; k++) begin
         int jl, ra, sp;
         vec_plan.delete();
         drop_plan.delete();
         drop_pct = 25;
         jl = $urandom_range(0, 6);
         ra = -1;
         sp = -1;
         if (jl > 0 && $urandom_range(0, 5) == 0) ra = $urandom_range(1, jl * PERIOD + 20);
         if ($urandom_range(0, 2) == 0) sp = $urandom_range(2, jl * PERIOD + 20);
         run_job(jl, ra, sp);
         idle_cycles($urandom_range(0, 6));
      end

      idle_cycles(3);
      mon_on = 1'b0;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
